// File: rtl/result_serializer_pkg.sv
// rtl/result_serializer_pkg.sv - shared opcodes, mode field layout and FSM states
package result_serializer_pkg;

    typedef enum logic [3:0] {
        OP_LOAD = 4'h0,
        OP_FWD  = 4'h1,
        OP_BWD  = 4'h2,
        OP_READ = 4'h3
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE,
        ST_ARM
    } state_e;

    localparam int MODE_OP_LSB   = 12;
    localparam int MODE_OP_W     = 4;
    localparam int MODE_CNT_LSB  = 4;
    localparam int MODE_CNT_W    = 8;
    localparam int MODE_BANK_LSB = 0;
    localparam int MODE_BANK_W   = 4;

    // The command carries count-1 so that a full 256-word readout fits in 8 bits.
    function automatic logic [MODE_CNT_W:0] word_count(input logic [MODE_CNT_W-1:0] cnt_m1);
        return {1'b0, cnt_m1} + (MODE_CNT_W + 1)'(1);
    endfunction

endpackage

// File: rtl/result_serializer_if.sv
// rtl/result_serializer_if.sv - result memory read port plus serial output stream
interface result_serializer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     out_ready;
    logic                     out_valid;
    logic                     out_bit;
    logic                     out_last;

    modport master (
        output rd_en, rd_addr, out_valid, out_bit, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_valid, out_bit, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/result_serializer_word_shifter.sv
// rtl/result_serializer_word_shifter.sv - shift register, prefetch holding register and bit counter
module word_shifter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              rsp_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    input  logic              accept_i,
    output logic              load_o,
    output logic              hold_vld_o,
    output logic              vld_o,
    output logic              bit_o,
    output logic              last_bit_o
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] sh_q, sh_d, hold_q, hold_d;
    logic              sh_vld_q, sh_vld_d, hold_vld_q, hold_vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_bit, take_word;

    assign last_bit   = sh_vld_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign take_word  = !sh_vld_q || (accept_i && last_bit);
    assign load_o     = en_i && take_word && (hold_vld_q || rsp_i);
    assign hold_vld_o = hold_vld_q;
    assign vld_o      = sh_vld_q;
    assign bit_o      = sh_vld_q & sh_q[0];
    assign last_bit_o = last_bit;

    always_comb begin
        sh_d       = sh_q;
        sh_vld_d   = sh_vld_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (load_o) begin
            sh_d     = hold_vld_q ? hold_q : rsp_data_i;
            sh_vld_d = 1'b1;
            cnt_d    = '0;
            if (hold_vld_q) begin
                hold_vld_d = 1'b0;
            end
        end else if (en_i && accept_i) begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_bit) begin
                sh_vld_d = 1'b0;
            end
        end
        // rd_data is only valid for one cycle, so a response is parked even while frozen.
        if (rsp_i && !(load_o && !hold_vld_q)) begin
            hold_d     = rsp_data_i;
            hold_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q       <= '0;
            sh_vld_q   <= 1'b0;
            cnt_q      <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            sh_vld_q   <= sh_vld_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
endmodule

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - reads N result words from memory and streams them out LSB first
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [31:0]          mode,
    output logic                 busy,
    output logic                 done,
    result_serializer_if.master  bus
);
    localparam int CW = MODE_CNT_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     n_q, n_d, issued_q, issued_d, loaded_q, loaded_d;
    logic              rsp_q;
    logic              start, issue, accept, word_last, opcode_read;
    logic              word_load, hold_vld, sh_vld, sh_bit, sh_last_bit;
    logic              unused_mode_hi;

    assign unused_mode_hi = ^mode[31:16];
    assign opcode_read    = (opcode_e'(mode[MODE_OP_LSB +: MODE_OP_W]) == OP_READ);
    assign start          = enable && opcode_read;

    // At most one word is in flight or parked, so the holding register can never be overrun.
    assign issue = enable && ((state_q == ST_FETCH) || (state_q == ST_SHIFT))
                   && (issued_q < n_q) && !hold_vld && !rsp_q;

    assign accept    = enable && sh_vld && bus.out_ready;
    assign word_last = sh_last_bit && (loaded_q == n_q);

    assign bus.rd_en     = issue;
    assign bus.rd_addr   = addr_q;
    assign bus.out_valid = sh_vld;
    assign bus.out_bit   = sh_bit;
    assign bus.out_last  = word_last;
    assign busy          = (state_q == ST_FETCH) || (state_q == ST_SHIFT);
    assign done          = (state_q == ST_DONE);

    word_shifter #(.DATA_W(DATA_W)) u_word_shifter (
        .clk        (clk),
        .reset      (reset),
        .en_i       (enable),
        .rsp_i      (rsp_q),
        .rsp_data_i (bus.rd_data),
        .accept_i   (accept),
        .load_o     (word_load),
        .hold_vld_o (hold_vld),
        .vld_o      (sh_vld),
        .bit_o      (sh_bit),
        .last_bit_o (sh_last_bit)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        n_d      = n_q;
        issued_d = issued_q;
        loaded_d = loaded_q;
        if (issue) begin
            addr_d   = addr_q + ADDR_W'(1);
            issued_d = issued_q + CW'(1);
        end
        if (word_load) begin
            loaded_d = loaded_q + CW'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    n_d      = word_count(mode[MODE_CNT_LSB +: MODE_CNT_W]);
                    addr_d   = ADDR_W'({mode[MODE_BANK_LSB +: MODE_BANK_W], 4'h0});
                    issued_d = '0;
                    loaded_d = '0;
                end
            end
            ST_FETCH: if (word_load)            state_d = ST_SHIFT;
            ST_SHIFT: if (accept && word_last)  state_d = ST_DONE;
            ST_DONE:  if (enable)               state_d = ST_ARM;
            ST_ARM:   if (enable && !opcode_read) state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            n_q      <= '0;
            issued_q <= '0;
            loaded_q <= '0;
            rsp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            n_q      <= n_d;
            issued_q <= issued_d;
            loaded_q <= loaded_d;
            rsp_q    <= issue;
        end
    end
endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - directed self-checking bench for result_serializer
module tb_result_serializer;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] mode;
    logic        busy, done;

    result_serializer_if #(.DATA_W(32), .ADDR_W(8)) bus ();

    result_serializer #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .busy   (busy),
        .done   (done),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic [7:0]  rd_log [$];

    // Synchronous result memory: data appears the cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        if (bus.rd_en === 1'b1) begin
            bus.rd_data <= mem[bus.rd_addr];
            rd_log.push_back(bus.rd_addr);
        end else begin
            bus.rd_data <= 32'h5A5A_A5A5;
        end
    end

    int           errors = 0;
    int           checks = 0;
    logic [127:0] got_bits, got_last;
    int           got_n, got_cycles, hold_viol;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept nbits from the stream; called and returning on a negedge.
    task automatic collect(input int nbits, input bit toggle, input int max_cycles);
        logic prev_stall, prev_bit;
        got_bits = '0; got_last = '0; got_n = 0; got_cycles = 0; hold_viol = 0;
        prev_stall = 1'b0; prev_bit = 1'b0;
        while (got_n < nbits && got_cycles < max_cycles) begin
            bus.out_ready = toggle ? got_cycles[0] : 1'b1;
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_bit !== prev_bit))
                hold_viol++;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                got_bits[got_n] = bus.out_bit;
                got_last[got_n] = bus.out_last;
                got_n++;
            end
            prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
            prev_bit   = bus.out_bit;
            got_cycles++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic go_idle();
        mode = 32'h0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen;
        logic [9:0]  part;
        logic [13:0] snap;
        logic [31:0] w4;
        logic [23:0] addrs;
        int          rd_base;

        reset = 1'b0; enable = 1'b0; mode = 32'h0; bus.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0]  = 32'h0000_0005;
        mem[16] = 32'hFFFF_FFFF;
        mem[17] = 32'h0000_0000;
        mem[18] = 32'hFFFF_FFFE;
        mem[32] = 32'hA5C3_0F96;
        mem[48] = 32'h1234_5678;
        w4 = mem[48];

        repeat (2) @(negedge clk);
        chk("reset_outputs", {bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_bit,
                              bus.out_last, busy, done}, 0);
        reset = 1'b1; enable = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("idle_no_start", {busy, bus.rd_en}, 0);

        // single word
        mode = 32'h3000;
        @(negedge clk);
        chk("fetch_rd", {busy, bus.rd_en, bus.rd_addr, bus.out_valid}, {1'b1, 1'b1, 8'h00, 1'b0});
        @(negedge clk);
        chk("fetch_wait", {busy, bus.rd_en, bus.out_valid}, 3'b100);
        @(negedge clk);
        chk("first_valid", {bus.out_valid, bus.out_bit}, 2'b11);
        collect(32, 1'b0, 200);
        chk("single_bits", got_bits, 128'h5);
        chk("single_last", got_last, 128'h1 << 31);
        chk("single_cycles", got_cycles, 32);
        chk("single_done", {done, busy, bus.out_valid}, 3'b100);
        @(negedge clk);
        chk("done_pulse_end", done, 0);

        // opcode held after done
        seen = 1'b0;
        repeat (5) begin
            seen = seen | busy | bus.rd_en;
            @(negedge clk);
        end
        chk("held_no_retrigger", seen, 0);
        mode = 32'h0;
        @(negedge clk);
        mode = 32'h3000;
        @(negedge clk);
        chk("rearm_start", {busy, bus.rd_en, bus.rd_addr}, {1'b1, 1'b1, 8'h00});
        repeat (2) @(negedge clk);
        collect(32, 1'b0, 200);
        chk("rearm_bits", got_bits, 128'h5);

        // streaming three words from bank 1
        go_idle();
        rd_base = rd_log.size();
        mode = 32'h3021;
        @(negedge clk);
        chk("stream_fetch", {bus.rd_en, bus.rd_addr}, {1'b1, 8'd16});
        repeat (2) @(negedge clk);
        collect(96, 1'b0, 400);
        chk("stream_bits", got_bits, {32'h0, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF});
        chk("stream_last", got_last, 128'h1 << 95);
        chk("stream_no_gaps", got_cycles, 96);
        chk("stream_done", done, 1);
        chk("stream_rd_count", rd_log.size() - rd_base, 3);
        addrs = (rd_log.size() >= rd_base + 3) ?
                {rd_log[rd_base], rd_log[rd_base+1], rd_log[rd_base+2]} : 24'hxxxxxx;
        chk("stream_addrs", addrs, {8'd16, 8'd17, 8'd18});

        // backpressure, ready toggling every cycle
        go_idle();
        mode = 32'h3002;
        repeat (3) @(negedge clk);
        collect(32, 1'b1, 200);
        chk("bp_bits", got_bits, 128'hA5C3_0F96);
        chk("bp_cycles", got_cycles, 64);
        chk("bp_hold_stable", hold_viol, 0);
        chk("bp_last", got_last, 128'h1 << 31);

        // enable low for five cycles mid-word
        go_idle();
        mode = 32'h3003;
        repeat (3) @(negedge clk);
        collect(10, 1'b0, 100);
        part = got_bits[9:0];
        chk("freeze_next_bit", {bus.out_valid, bus.out_bit}, {1'b1, w4[10]});
        snap = {bus.out_valid, bus.out_bit, bus.out_last, busy, done, bus.rd_en, bus.rd_addr};
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("freeze_hold", {bus.out_valid, bus.out_bit, bus.out_last, busy, done,
                                bus.rd_en, bus.rd_addr}, snap);
        end
        enable = 1'b1;
        collect(22, 1'b0, 100);
        chk("freeze_resume_bits", {got_bits[21:0], part}, w4);
        chk("freeze_resume_last", got_last, 128'h1 << 21);

        // asynchronous reset at bit 10 of word 2
        go_idle();
        mode = 32'h3021;
        repeat (3) @(negedge clk);
        collect(42, 1'b0, 200);
        chk("pre_reset_bits", got_bits, {86'h0, 10'h0, 32'hFFFF_FFFF});
        #2;
        reset = 1'b0;
        mode  = 32'h0;
        #1;
        chk("async_reset_outputs", {bus.rd_en, bus.rd_addr, bus.out_valid, bus.out_bit,
                                    bus.out_last, busy, done}, 0);
        @(negedge clk);
        reset = 1'b1;
        mode  = 32'h3000;
        @(negedge clk);
        chk("post_reset_fetch", {busy, bus.rd_en, bus.rd_addr}, {1'b1, 1'b1, 8'h00});
        repeat (2) @(negedge clk);
        collect(32, 1'b0, 200);
        chk("post_reset_bits", got_bits, 128'h5);
        chk("post_reset_last", got_last, 128'h1 << 31);
        go_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, result word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, result memory address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  global run enable; when low, all state holds.
REQ-006 SHALL have port mode  input  32  command word: [15:12] opcode, [11:4] word count minus 1, [3:0] base bank.
REQ-007 SHALL have port rd_en  output  1  result memory read strobe.
REQ-008 SHALL have port rd_addr  output  ADDR_W  result memory read address.
REQ-009 SHALL have port rd_data  input  DATA_W  signed read data, valid exactly 1 cycle after rd_en.
REQ-010 SHALL have port out_ready  input  1  host accepts a bit this cycle.
REQ-011 SHALL have port out_valid  output  1  out_bit is valid.
REQ-012 SHALL have port out_bit  output  1  serial result bit, LSB first.
REQ-013 SHALL have port out_last  output  1  marks the MSB of the final word.
REQ-014 SHALL have ports busy and done  output  1 each  readout in progress; 1-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, FETCH, SHIFT, DONE, ARM.
REQ-016 SHALL leave IDLE for FETCH when enable=1 and mode[15:12]=4'h3, latching N=mode[11:4]+1 (1..256) and base=mode[3:0]*16.
REQ-017 SHALL, in FETCH, assert rd_en for one cycle with rd_addr=base, then load rd_data into the shift register one cycle later and enter SHIFT.
REQ-018 SHALL assert out_valid two cycles after the start-sampling edge, with out_bit = shift register bit 0.
REQ-019 SHALL advance one bit only on a cycle with out_valid=1, out_ready=1 and enable=1; otherwise out_bit holds stable.
REQ-020 SHALL prefetch the next word (rd_addr incremented by 1, wrapping modulo 2^ADDR_W) into a holding register while the current word shifts, so back-to-back words stream with no gap when out_ready stays high.
REQ-021 SHALL assert out_last only on bit DATA_W-1 of word N.
REQ-022 SHALL enter DONE after that bit is accepted, pulse done for exactly one cycle, then enter ARM.
REQ-023 SHALL remain in ARM until mode[15:12]!=4'h3, then return to IDLE, so that a held opcode never retriggers.
REQ-024 SHALL keep busy=1 in FETCH and SHIFT only.
REQ-025 SHALL ignore mode changes while busy.
REQ-026 SHALL freeze all state and outputs while enable=0, and resume exactly where it stopped.
REQ-027 SHALL never issue rd_en beyond word N.

Reset
REQ-028 SHALL, on reset=0 at any time including mid-word, return immediately to IDLE with rd_en=0, rd_addr=0, out_valid=0, out_bit=0, out_last=0, busy=0, done=0, and the counters and shift/holding registers cleared.

Structure
REQ-029 SHALL take the opcode constants (LOAD=0, FWD=1, BWD=2, READ=3), the mode field positions and the state enum from the shared package.
REQ-030 SHALL place the shift register, holding register and bit counter in one sub-module, word_shifter; the FSM and address counter stay at top level.

Verification
REQ-031 SHALL verify single word: mem[0]=32'h0000_0005, mode=32'h3000, out_ready=1 -> bits 1,0,1 then 29 zeros; out_last on bit 31; done 1 cycle later.
REQ-032 SHALL verify streaming: mode=32'h3021, mem[16..18]=-1,0,-2 -> 96 consecutive valid cycles with no gaps, out_last only on the final bit, rd_addr 16,17,18.
REQ-033 SHALL verify backpressure: toggle out_ready every cycle during a word -> each bit held until accepted; bit order unchanged; 64 cycles per word.
REQ-034 SHALL verify enable=0 for 5 cycles mid-word -> no state or output change; the stream resumes with the next unaccepted bit.
REQ-035 SHALL verify reset=0 asserted at bit 10 of word 2 -> all outputs 0 asynchronously; a new mode=32'h3000 after release restarts from mem[0].
REQ-036 SHALL verify that mode held at 32'h3000 after done -> no second readout until mode goes to 0 and back.
